// File: rtl/wqe_segmenter_if.sv
// Bus bundle between the WQE cache, the segmenter and the packet builder.
// The master modport is the segmenter's view; slave is the surrounding logic.
interface wqe_segmenter_if #(
  parameter int WQE_WIDTH    = 512,
  parameter int QP_PTR_WIDTH = 4,
  parameter int LEN_WIDTH    = 32
);
  logic                    i_wqe_cache_empty;
  logic                    o_wqe_cache_rd;
  logic                    i_wqe_val;
  logic [WQE_WIDTH-1:0]    i_wqe;
  logic                    o_pkt_val;
  logic                    i_pkt_rdy;
  logic [QP_PTR_WIDTH-1:0] o_pkt_qpn;
  logic [63:0]             o_pkt_wrid;
  logic [7:0]              o_pkt_opcode;
  logic [63:0]             o_pkt_addr;
  logic [LEN_WIDTH-1:0]    o_pkt_len;
  logic                    o_pkt_first;
  logic                    o_pkt_last;

  modport master (
    input  i_wqe_cache_empty, i_wqe_val, i_wqe, i_pkt_rdy,
    output o_wqe_cache_rd, o_pkt_val, o_pkt_qpn, o_pkt_wrid, o_pkt_opcode,
           o_pkt_addr, o_pkt_len, o_pkt_first, o_pkt_last
  );

  modport slave (
    output i_wqe_cache_empty, i_wqe_val, i_wqe, i_pkt_rdy,
    input  o_wqe_cache_rd, o_pkt_val, o_pkt_qpn, o_pkt_wrid, o_pkt_opcode,
           o_pkt_addr, o_pkt_len, o_pkt_first, o_pkt_last
  );
endinterface

// File: rtl/wqe_segmenter.sv
// Pops WQEs from the TX WQE cache (1-cycle read latency) and splits each
// payload into MTU-sized packet descriptors on a valid/ready handshake.
module wqe_segmenter #(
  parameter int WQE_WIDTH    = 512,
  parameter int QP_PTR_WIDTH = 4,
  parameter int LEN_WIDTH    = 32,
  parameter int MTU_LOG2     = 12
) (
  input  logic             clk,
  input  logic             rst,
  wqe_segmenter_if.master  io_bus,
  output logic             o_busy,
  output logic             o_protocol_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEG} state_t;

  localparam logic [LEN_WIDTH-1:0] MTU = LEN_WIDTH'(1) << MTU_LOG2;

  state_t                  r_state, w_nxt;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic [63:0]             r_addr;
  logic [63:0]             r_wrid;
  logic [7:0]              r_opcode;
  logic [QP_PTR_WIDTH-1:0] r_qpn;
  logic                    r_first;
  logic                    r_perr;

  logic w_seg, w_last, w_hs, w_rd, w_load;

  assign w_seg  = (r_state == S_SEG);
  assign w_last = (r_rem <= MTU);
  assign w_hs   = w_seg & io_bus.i_pkt_rdy;

  always_comb begin
    w_nxt  = r_state;
    w_rd   = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: if (!io_bus.i_wqe_cache_empty) begin
        w_rd  = 1'b1;
        w_nxt = S_WAIT;
      end
      S_WAIT: if (io_bus.i_wqe_val) begin
        w_load = 1'b1;
        w_nxt  = S_SEG;
      end
      S_SEG: if (w_hs && w_last) begin
        // chain straight into the next pop so back-to-back WQEs lose no cycle
        if (!io_bus.i_wqe_cache_empty) begin
          w_rd  = 1'b1;
          w_nxt = S_WAIT;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_addr   <= '0;
      r_wrid   <= '0;
      r_opcode <= '0;
      r_qpn    <= '0;
      r_first  <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_perr  <= io_bus.i_wqe_val & (r_state != S_WAIT);
      if (w_load) begin
        r_rem    <= io_bus.i_wqe[72 +: LEN_WIDTH];
        r_addr   <= io_bus.i_wqe[191:128];
        r_wrid   <= io_bus.i_wqe[63:0];
        r_opcode <= io_bus.i_wqe[71:64];
        r_qpn    <= io_bus.i_wqe[328 +: QP_PTR_WIDTH];
        r_first  <= 1'b1;
      end else if (w_hs && !w_last) begin
        r_rem   <= r_rem - MTU;
        r_addr  <= r_addr + 64'(MTU);
        r_first <= 1'b0;
      end
    end
  end

  // a pop during reset would lose a cache entry, so gate it
  assign io_bus.o_wqe_cache_rd = w_rd & ~rst;
  assign io_bus.o_pkt_val      = w_seg;
  assign io_bus.o_pkt_qpn      = r_qpn;
  assign io_bus.o_pkt_wrid     = r_wrid;
  assign io_bus.o_pkt_opcode   = r_opcode;
  assign io_bus.o_pkt_addr     = r_addr;
  assign io_bus.o_pkt_len      = w_seg ? (w_last ? r_rem : MTU) : '0;
  assign io_bus.o_pkt_first    = w_seg & r_first;
  assign io_bus.o_pkt_last     = w_seg & w_last;
  assign o_busy                = (r_state != S_IDLE);
  assign o_protocol_err        = r_perr;

endmodule

// File: tb/tb_wqe_segmenter.sv
// Directed bench for wqe_segmenter with a small 1-cycle-latency cache model.
module tb_wqe_segmenter;

  logic clk = 1'b0;
  logic rst;
  logic busy, perr;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wqe_segmenter_if #(.WQE_WIDTH(512), .QP_PTR_WIDTH(4), .LEN_WIDTH(32)) bus ();

  wqe_segmenter #(
    .WQE_WIDTH(512), .QP_PTR_WIDTH(4), .LEN_WIDTH(32), .MTU_LOG2(12)
  ) dut (
    .clk(clk), .rst(rst), .io_bus(bus), .o_busy(busy), .o_protocol_err(perr)
  );

  // cache model: initial block pushes, responder pops
  logic [511:0] mem [0:15];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic         rsp_val = 1'b0;
  logic [511:0] rsp_data = '0;
  logic         spur;
  logic         rdy;

  always @(posedge clk) begin
    if (bus.o_wqe_cache_rd && (rd_ptr != wr_ptr)) begin
      rsp_val  <= 1'b1;
      rsp_data <= mem[rd_ptr[3:0]];
      rd_ptr   <= rd_ptr + 1;
    end else begin
      rsp_val  <= 1'b0;
    end
  end

  assign bus.i_wqe_cache_empty = (wr_ptr == rd_ptr);
  assign bus.i_wqe_val         = rsp_val | spur;
  assign bus.i_wqe             = rsp_val ? rsp_data : {512{1'b1}};
  assign bus.i_pkt_rdy         = rdy;

  function automatic logic [511:0] mkwqe(logic [31:0] len, logic [63:0] addr,
                                         logic [3:0] qpn, logic [63:0] wrid,
                                         logic [7:0] opc);
    logic [511:0] w;
    w = '0;
    w[63:0]    = wrid;
    w[71:64]   = opc;
    w[103:72]  = len;
    w[191:128] = addr;
    w[331:328] = qpn;
    return w;
  endfunction

  task automatic push(logic [511:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_desc(string tag, logic [31:0] len, logic [63:0] addr,
                          logic first, logic last, logic [3:0] qpn, logic [63:0] wrid);
    chk({tag, ".val"},   64'(bus.o_pkt_val),   64'd1);
    chk({tag, ".len"},   64'(bus.o_pkt_len),   64'(len));
    chk({tag, ".addr"},  bus.o_pkt_addr,       addr);
    chk({tag, ".first"}, 64'(bus.o_pkt_first), 64'(first));
    chk({tag, ".last"},  64'(bus.o_pkt_last),  64'(last));
    chk({tag, ".qpn"},   64'(bus.o_pkt_qpn),   64'(qpn));
    chk({tag, ".wrid"},  bus.o_pkt_wrid,       wrid);
  endtask

  task automatic chk_idle(string tag);
    chk({tag, ".val"},  64'(bus.o_pkt_val), 64'd0);
    chk({tag, ".busy"}, 64'(busy),          64'd0);
  endtask

  initial begin
    rst  = 1'b1;
    rdy  = 1'b0;
    spur = 1'b0;
    step(); step();
    chk("rst.val",   64'(bus.o_pkt_val),      64'd0);
    chk("rst.busy",  64'(busy),               64'd0);
    chk("rst.perr",  64'(perr),               64'd0);
    chk("rst.rd",    64'(bus.o_wqe_cache_rd), 64'd0);
    chk("rst.first", 64'(bus.o_pkt_first),    64'd0);
    chk("rst.last",  64'(bus.o_pkt_last),     64'd0);
    chk("rst.len",   64'(bus.o_pkt_len),      64'd0);
    chk("rst.qpn",   64'(bus.o_pkt_qpn),      64'd0);
    rst = 1'b0;
    rdy = 1'b1;
    step();

    // single short WQE: rd at T, val at T+1, descriptor at T+2
    push(mkwqe(32'd100, 64'h1000, 4'd3, 64'hAB, 8'h0A));
    #1 chk("t1.rd", 64'(bus.o_wqe_cache_rd), 64'd1);
    step();
    chk("t1.wait.val", 64'(bus.o_pkt_val), 64'd0);
    chk("t1.wait.rd",  64'(bus.o_wqe_cache_rd), 64'd0);
    chk("t1.wait.busy", 64'(busy), 64'd1);
    step();
    chk_desc("t1.d0", 32'd100, 64'h1000, 1'b1, 1'b1, 4'd3, 64'hAB);
    chk("t1.opcode", 64'(bus.o_pkt_opcode), 64'h0A);
    step();
    chk_idle("t1.end");

    // 10000 bytes -> 4096, 4096, 1808
    push(mkwqe(32'd10000, 64'h0, 4'd1, 64'h11, 8'h01));
    step(); step();
    chk_desc("t2.d0", 32'd4096, 64'h0000, 1'b1, 1'b0, 4'd1, 64'h11);
    step();
    chk_desc("t2.d1", 32'd4096, 64'h1000, 1'b0, 1'b0, 4'd1, 64'h11);
    step();
    chk_desc("t2.d2", 32'd1808, 64'h2000, 1'b0, 1'b1, 4'd1, 64'h11);
    step();
    chk_idle("t2.end");

    // exact multiple of MTU: no trailing zero-length descriptor
    push(mkwqe(32'd8192, 64'h4000, 4'd2, 64'h22, 8'h02));
    step(); step();
    chk_desc("t3.d0", 32'd4096, 64'h4000, 1'b1, 1'b0, 4'd2, 64'h22);
    step();
    chk_desc("t3.d1", 32'd4096, 64'h5000, 1'b0, 1'b1, 4'd2, 64'h22);
    step();
    chk_idle("t3.end");

    // zero length
    push(mkwqe(32'd0, 64'h5000, 4'd4, 64'h33, 8'h03));
    step(); step();
    chk_desc("t4.d0", 32'd0, 64'h5000, 1'b1, 1'b1, 4'd4, 64'h33);
    step();
    chk_idle("t4.end");

    // backpressure on segment 2 for 5 cycles
    push(mkwqe(32'd10000, 64'h8000, 4'd9, 64'h44, 8'h04));
    step(); step();
    chk_desc("t5.d0", 32'd4096, 64'h8000, 1'b1, 1'b0, 4'd9, 64'h44);
    step();
    chk_desc("t5.d1", 32'd4096, 64'h9000, 1'b0, 1'b0, 4'd9, 64'h44);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_desc("t5.hold", 32'd4096, 64'h9000, 1'b0, 1'b0, 4'd9, 64'h44);
    end
    rdy = 1'b1;
    step();
    chk_desc("t5.d2", 32'd1808, 64'hA000, 1'b0, 1'b1, 4'd9, 64'h44);
    step();
    chk_idle("t5.end");

    // back-to-back WQEs
    push(mkwqe(32'd4097, 64'h100, 4'd5, 64'h55, 8'h05));
    push(mkwqe(32'd50,   64'h200, 4'd6, 64'h66, 8'h06));
    step(); step();
    chk_desc("t6.a0", 32'd4096, 64'h0100, 1'b1, 1'b0, 4'd5, 64'h55);
    chk("t6.a0.rd", 64'(bus.o_wqe_cache_rd), 64'd0);
    step();
    chk_desc("t6.a1", 32'd1, 64'h1100, 1'b0, 1'b1, 4'd5, 64'h55);
    chk("t6.a1.rd", 64'(bus.o_wqe_cache_rd), 64'd1);
    step();
    chk("t6.wait.val", 64'(bus.o_pkt_val), 64'd0);
    chk("t6.wait.rd",  64'(bus.o_wqe_cache_rd), 64'd0);
    step();
    chk_desc("t6.b0", 32'd50, 64'h200, 1'b1, 1'b1, 4'd6, 64'h66);
    step();
    chk_idle("t6.end");

    // reset during segment 2 of 3, then next entry runs normally
    push(mkwqe(32'd10000, 64'h20000, 4'd7, 64'h77, 8'h07));
    push(mkwqe(32'd20,    64'h300,   4'd8, 64'h88, 8'h08));
    step(); step();
    chk_desc("t7.c0", 32'd4096, 64'h20000, 1'b1, 1'b0, 4'd7, 64'h77);
    step();
    chk_desc("t7.c1", 32'd4096, 64'h21000, 1'b0, 1'b0, 4'd7, 64'h77);
    rst = 1'b1;
    #1 chk("t7.rst.rd", 64'(bus.o_wqe_cache_rd), 64'd0);
    step();
    chk_idle("t7.rst");
    chk("t7.rst.last", 64'(bus.o_pkt_last), 64'd0);
    rst = 1'b0;
    #1 chk("t7.rel.rd", 64'(bus.o_wqe_cache_rd), 64'd1);
    step(); step();
    chk_desc("t7.d0", 32'd20, 64'h300, 1'b1, 1'b1, 4'd8, 64'h88);
    step();
    chk_idle("t7.end");
    chk("t7.perr", 64'(perr), 64'd0);

    // spurious read-data valid while idle
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("t8.perr1", 64'(perr), 64'd1);
    chk_idle("t8.p1");
    step();
    chk("t8.perr0", 64'(perr), 64'd0);
    chk_idle("t8.p0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
